// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, scan
// classification and the column/row to hex key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } scan_class_e;

  typedef struct packed {
    scan_class_e cls;
    logic [3:0]  code;
  } scan_result_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Indexed by {col,row}: col0 = 1,4,7,0 ... col3 = A,B,C,D
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic scan_result_t classify(input logic [15:0] pressed);
    scan_result_t res;
    int unsigned  hits;
    res.cls  = CLS_NONE;
    res.code = 4'h0;
    hits     = 0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i[3:0]]) begin
        hits++;
        res.code = KEY_MAP[i[3:0]];
      end
    end
    if (hits == 1) begin
      res.cls = CLS_SINGLE;
    end else if (hits > 1) begin
      res.cls = CLS_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin and key-output bundle of the keypad scanner; master is the scanner,
// slave is the board/consumer side.
interface keypad_scanner_if;
  logic [3:0]  kpCol;
  logic [3:0]  kpRow;
  logic        bufClear;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyHeld;
  logic [31:0] keyBuffer;

  modport master (
    output kpCol, keyCode, keyValid, keyHeld, keyBuffer,
    input  kpRow, bufClear
  );

  modport slave (
    input  kpCol, keyCode, keyValid, keyHeld, keyBuffer,
    output kpRow, bufClear
  );
endinterface

// File: rtl/clockDividerHB2.sv
// Free-running divider: counts 0..THRESHOLD-1 and raises beat for the one
// cycle the count sits at THRESHOLD-1. beat is a clock enable, not a clock.
module clockDividerHB2 #(
  parameter int THRESHOLD = 125_000
) (
  input  logic clk,
  input  logic reset,
  output logic beat
);

  localparam int CNT_W = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign beat = (count_q == LAST);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (beat) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/keypad_debounce_fsm.sv
// Scan-rate debounce FSM: turns per-scan classifications into accepted keys.
// KEYPAD_AUTOREPEAT_EN adds held-key auto-repeat pulses in PRESSED.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 100,
  parameter int REPEAT_RATE_SCANS  = 25
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_end_i,
  input  scan_class_e class_i,
  input  logic [3:0]  code_i,
  output logic        accept_o,
  output logic [3:0]  code_o,
  output logic        held_o
);

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

  kp_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                           REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY_SCANS);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE_SCANS);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
`endif

  assign held_o = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
  assign code_o = cand_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_o = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    // Repeat timing restarts whenever a new press is being qualified
    if ((state_q == ST_IDLE) || (state_q == ST_DEBOUNCE)) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
`endif
    if (scan_end_i) begin
      case (state_q)
        ST_IDLE: begin
          if (class_i == CLS_SINGLE) begin
            cand_d = code_i;
            cnt_d  = 4'd1;
            if (DEB_TARGET <= 4'd1) begin
              state_d  = ST_PRESSED;
              accept_o = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if ((class_i == CLS_SINGLE) && (code_i == cand_q)) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d >= DEB_TARGET) begin
              state_d  = ST_PRESSED;
              accept_o = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (class_i == CLS_NONE) begin
            cnt_d = 4'd1;
            if (DEB_TARGET <= 4'd1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            if (rpt_cnt_d == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
              accept_o    = 1'b1;
              rpt_cnt_d   = '0;
              rpt_first_d = 1'b0;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (class_i == CLS_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d >= DEB_TARGET) begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, debounce and a
// 4-byte key history. KEYPAD_AUTOREPEAT_EN enables held-key auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_THRESHOLD = 125_000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 100,
  parameter int REPEAT_RATE_SCANS  = 25
`endif
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  logic [3:0]   row_meta_q, row_sync_q;
  logic         scan_tick;
  logic         scan_end;
  logic [3:0]   col_q;
  logic [1:0]   col_idx_q;
  logic [11:0]  snap_q;
  logic [15:0]  snap_full;
  scan_result_t scan_res;
  logic         accept;
  logic [3:0]   accept_code;
  logic         held;
  logic         key_valid_q;
  logic [3:0]   key_code_q;
  logic [31:0]  key_buf_q, key_buf_d;

  // Rows are asynchronous to clk
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp.kpRow;
      row_sync_q <= row_meta_q;
    end
  end

  clockDividerHB2 #(
    .THRESHOLD(SCAN_THRESHOLD)
  ) u_scan_div (
    .clk  (clk),
    .reset(reset),
    .beat (scan_tick)
  );

  // Snapshot holds pressed=1 for cols 0..2; col3 is merged live at scan end
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= COL_RESET;
      col_idx_q <= 2'd0;
      snap_q    <= '0;
    end else if (scan_tick) begin
      col_q     <= {col_q[2:0], col_q[3]};
      col_idx_q <= col_idx_q + 2'd1;
      case (col_idx_q)
        2'd0:    snap_q[3:0]  <= ~row_sync_q;
        2'd1:    snap_q[7:4]  <= ~row_sync_q;
        2'd2:    snap_q[11:8] <= ~row_sync_q;
        default: ;
      endcase
    end
  end

  assign scan_end  = scan_tick && (col_idx_q == 2'd3);
  assign snap_full = {~row_sync_q, snap_q};
  assign scan_res  = classify(snap_full);

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_SCANS(REPEAT_DELAY_SCANS),
    .REPEAT_RATE_SCANS (REPEAT_RATE_SCANS)
`endif
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .scan_end_i(scan_end),
    .class_i   (scan_res.cls),
    .code_i    (scan_res.code),
    .accept_o  (accept),
    .code_o    (accept_code),
    .held_o    (held)
  );

  // A clear coinciding with an acceptance empties history before the shift
  always_comb begin
    key_buf_d = key_buf_q;
    if (accept) begin
      key_buf_d = {(kp.bufClear ? 24'h0 : key_buf_q[23:0]), 4'h0, accept_code};
    end else if (kp.bufClear) begin
      key_buf_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_buf_q   <= '0;
    end else begin
      key_valid_q <= accept;
      key_buf_q   <= key_buf_d;
      if (accept) begin
        key_code_q <= accept_code;
      end
    end
  end

  assign kp.kpCol     = col_q;
  assign kp.keyCode   = key_code_q;
  assign kp.keyValid  = key_valid_q;
  assign kp.keyHeld   = held;
  assign kp.keyBuffer = key_buf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-level bench for keypad_scanner: a keypad matrix model resolves rows
// from kpCol, and a per-scan reference model predicts every output.
module tb_keypad_scanner;

  localparam int SCAN_T   = 4;
  localparam int DEB      = 2;
  localparam int RPT_D    = 3;
  localparam int RPT_R    = 2;
  localparam int SCAN_CYC = 4 * SCAN_T;

  localparam logic [3:0] TB_MAP [4][4] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row_drv;

  int n_chk = 0;
  int n_pass = 0;
  int n_valid_seen = 0;

  // Reference model state
  bit          exp_valid;
  logic [3:0]  exp_code;
  logic [31:0] exp_buf;
  bit          m_held;
  int          m_run;
  logic [3:0]  m_code;
  int          m_none;
  int          m_hscans;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_THRESHOLD(SCAN_T),
    .DEBOUNCE_SCANS(DEB)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_SCANS(RPT_D),
    .REPEAT_RATE_SCANS (RPT_R)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its column to its row
  always_comb begin
    row_drv = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (kp_if.kpCol[c] == 1'b0) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4+r]) row_drv[r] = 1'b0;
        end
      end
    end
  end
  assign kp_if.kpRow = row_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key(input logic [3:0] code);
    logic [15:0] m;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (TB_MAP[c][r] == code) m[c*4+r] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] code_of(input logic [15:0] mask);
    logic [3:0] cd;
    cd = 4'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[c*4+r]) cd = TB_MAP[c][r];
    return cd;
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_code = 4'h0; exp_buf = '0;
    m_held = 0; m_run = 0; m_code = 4'h0; m_none = 0; m_hscans = 0;
  endtask

  // One full scan with a stable key set: run-length rules for press/release
  task automatic model_scan(input logic [15:0] mask, input bit clr);
    int n;
    logic [3:0] cd;
    n = $countones(mask);
    cd = code_of(mask);
    exp_valid = 0;
    if (!m_held) begin
      if (n == 1 && (m_run == 0 || cd == m_code)) begin
        if (m_run == 0) m_code = cd;
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= DEB) begin
        exp_valid = 1; m_held = 1; m_none = 0; m_hscans = 0; m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_none++;
        if (m_none >= DEB) begin m_held = 0; m_run = 0; end
      end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_none == 0) begin
          m_hscans++;
          if (m_hscans == RPT_D || (m_hscans > RPT_D && (m_hscans - RPT_D) % RPT_R == 0))
            exp_valid = 1;
        end
`endif
        m_none = 0;
      end
    end
    if (exp_valid) begin
      exp_code = m_code;
      exp_buf  = {(clr ? 24'h0 : exp_buf[23:0]), 4'h0, m_code};
    end else if (clr) begin
      exp_buf = '0;
    end
  endtask

  // Starts and ends #1 after a scan-end edge; clr is applied on the scan-end edge
  task automatic do_scan(input logic [15:0] mask, input bit clr);
    logic [3:0] exp_col;
    keys = mask;
    model_scan(mask, clr);
    for (int e = 1; e <= SCAN_CYC; e++) begin
      if (e == SCAN_CYC) kp_if.bufClear = clr;
      @(posedge clk);
      #1;
      kp_if.bufClear = 1'b0;
      exp_col = ~(4'b0001 << ((e / SCAN_T) % 4));
      check("kpCol", {28'h0, kp_if.kpCol}, {28'h0, exp_col});
      check("keyValid", {31'h0, kp_if.keyValid}, {31'h0, (e == SCAN_CYC) ? exp_valid : 1'b0});
      n_valid_seen += int'(kp_if.keyValid);
    end
    check("keyCode", {28'h0, kp_if.keyCode}, {28'h0, exp_code});
    check("keyBuffer", kp_if.keyBuffer, exp_buf);
    check("keyHeld", {31'h0, kp_if.keyHeld}, {31'h0, m_held});
    $display("scan keys=%04h clr=%0d -> valid=%0d code=%h held=%0d buf=%08h",
             mask, clr, kp_if.keyValid, kp_if.keyCode, kp_if.keyHeld, kp_if.keyBuffer);
  endtask

  task automatic do_reset(input int mid_cycles);
    repeat (mid_cycles) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_kpCol", {28'h0, kp_if.kpCol}, 32'he);
    check("rst_keyValid", {31'h0, kp_if.keyValid}, 32'h0);
    check("rst_keyHeld", {31'h0, kp_if.keyHeld}, 32'h0);
    check("rst_keyCode", {28'h0, kp_if.keyCode}, 32'h0);
    check("rst_keyBuffer", kp_if.keyBuffer, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    $display("reset after %0d cycles", mid_cycles);
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    for (int i = 0; i < hold; i++) do_scan(key(code), 1'b0);
    for (int i = 0; i < rel; i++) do_scan('0, 1'b0);
  endtask

  initial begin
    int v0;
    int kind, len;
    logic [15:0] m;
    kp_if.bufClear = 1'b0;
    model_reset();

    // 1: idle scanning
    do_reset(0);
    for (int i = 0; i < 3; i++) do_scan('0, 1'b0);

    // 2: single key 5
    v0 = n_valid_seen;
    press(4'h5, 3, 3);
    check("t2_pulses", n_valid_seen - v0, 1);
    check("t2_buf", kp_if.keyBuffer, 32'h0000_0005);

    // 3: sequence 1,2,3,A,7
    v0 = n_valid_seen;
    press(4'h1, 3, 3); press(4'h2, 3, 3); press(4'h3, 3, 3);
    press(4'hA, 3, 3); press(4'h7, 3, 3);
    check("t3_pulses", n_valid_seen - v0, 5);
    check("t3_buf", kp_if.keyBuffer, 32'h0203_0A07);

    // bufClear alone
    do_scan('0, 1'b1);
    check("clr_alone", kp_if.keyBuffer, 32'h0);

    // 4: ghosting then single 4
    for (int i = 0; i < 3; i++) do_scan(key(4'h4) | key(4'h6), 1'b0);
    for (int i = 0; i < 2; i++) do_scan(key(4'h4), 1'b0);
    check("t4_code", {28'h0, kp_if.keyCode}, 32'h4);
    for (int i = 0; i < 3; i++) do_scan('0, 1'b0);

    // 5: bouncing 8, then again with clear on acceptance
    v0 = n_valid_seen;
    do_scan(key(4'h8), 1'b0); do_scan('0, 1'b0);
    do_scan(key(4'h8), 1'b0); do_scan(key(4'h8), 1'b0);
    for (int i = 0; i < 3; i++) do_scan('0, 1'b0);
    check("t5_pulses", n_valid_seen - v0, 1);
    do_scan(key(4'h8), 1'b0); do_scan('0, 1'b0);
    do_scan(key(4'h8), 1'b0); do_scan(key(4'h8), 1'b1);
    check("t5_clr_buf", kp_if.keyBuffer, 32'h0000_0008);
    for (int i = 0; i < 3; i++) do_scan('0, 1'b0);

    // 6: reset mid-press of D, re-accept while still held
    do_scan(key(4'hD), 1'b0); do_scan(key(4'hD), 1'b0);
    keys = key(4'hD);
    do_reset(7);
    do_scan(key(4'hD), 1'b0); do_scan(key(4'hD), 1'b0);
    check("t6_code", {28'h0, kp_if.keyCode}, 32'hD);
    check("t6_buf", kp_if.keyBuffer, 32'h0000_000D);
    for (int i = 0; i < 3; i++) do_scan('0, 1'b0);

`ifdef KEYPAD_AUTOREPEAT_EN
    v0 = n_valid_seen;
    press(4'hC, 9, 3);
    check("rpt_pulses", n_valid_seen - v0, 4);
`endif

    // Randomized key activity against the model
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 4);
      case (kind)
        0:       m = '0;
        1, 2:    m = 16'h1 << $urandom_range(0, 15);
        default: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      for (int s = 0; s < len; s++) do_scan(m, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
